sobel_window_ctrl: RTL and testbench

Raster-to-window scheduler between the grayscale stage and the Sobel kernel. Pulls one grayscale pixel per step from the grayscale FIFO in raster order and keeps the two previous image rows in internal line buffers. Emits one complete, zero-padded 3x3 window per output pixel into the kernel-side FIFO, exactly WIDTH*HEIGHT windows per frame. Replaces the ad-hoc three-rows-per-word feeding with correct border handling and frame sequencing (start/busy/done).

---
 rtl/sobel_window_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl.sv
// Raster-to-window scheduler: two line buffers plus a 3-column window yield zero-padded 3x3 windows.
// Optional macro SOBEL_CTRL_STALL_COUNT_EN adds a saturating 32-bit stall_count output.
module sobel_window_ctrl #(
   parameter int WIDTH  = 720,
   parameter int HEIGHT = 540,
   parameter int DWIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   input  logic [DWIDTH-1:0]     in_dout,
   input  logic                  in_empty,
   output logic                  in_rd_en,
   output logic [9*DWIDTH-1:0]   out_din,
   input  logic                  out_full,
   output logic                  out_wr_en
`ifdef SOBEL_CTRL_STALL_COUNT_EN
   ,
   output logic [31:0]           stall_count
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int RW = $clog2(HEIGHT + 1);
   localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH);
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [RW-1:0] R_LAST = RW'(HEIGHT);
   localparam logic [RW-1:0] R_ONE  = RW'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            c_q, c_d;
   logic [RW-1:0]            r_q, r_d;
   logic [2:0][DWIDTH-1:0]   left_q, left_d;
   logic [2:0][DWIDTH-1:0]   centre_q, centre_d;
   logic [2:0][DWIDTH-1:0]   col_new;
   logic [DWIDTH-1:0]        lb0_q [WIDTH];
   logic [DWIDTH-1:0]        lb1_q [WIDTH];
   logic [AW-1:0]            idx;
   logic                     real_pos, emit_pos, in_row, step;

   // Virtual grid position classification and the single step qualifier
   always_comb begin
      idx      = c_q[AW-1:0];
      in_row   = (c_q < C_LAST);
      real_pos = (r_q < R_LAST) && in_row;
      emit_pos = (r_q != '0) && (c_q != '0);
      busy     = (state_q == RUN);
      done     = (state_q == DONE);
      step     = busy && (!real_pos || !in_empty) && (!emit_pos || !out_full);
      in_rd_en  = step && real_pos;
      out_wr_en = step && emit_pos;
   end

   // Incoming column: rows above the image and the padding column read as zero
   always_comb begin
      col_new = '0;
      if ((r_q > R_ONE) && in_row)  col_new[0] = lb1_q[idx];
      if ((r_q != '0) && in_row)    col_new[1] = lb0_q[idx];
      if (busy && real_pos)         col_new[2] = in_dout;
   end

   always_comb begin
      out_din = '0;
      if (busy) begin
         for (int row = 0; row < 3; row++) begin
            out_din[DWIDTH*(row*3)   +: DWIDTH] = left_q[row];
            out_din[DWIDTH*(row*3+1) +: DWIDTH] = centre_q[row];
            out_din[DWIDTH*(row*3+2) +: DWIDTH] = col_new[row];
         end
      end
   end

   always_comb begin
      left_d   = left_q;
      centre_d = centre_q;
      if (step) begin
         left_d   = (c_q == '0) ? '0 : centre_q;
         centre_d = col_new;
      end
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      r_d     = r_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               c_d     = '0;
               r_d     = '0;
            end
         end
         RUN: begin
            if (step) begin
               if (c_q == C_LAST) begin
                  c_d = '0;
                  if (r_q == R_LAST) begin
                     r_d     = '0;
                     state_d = DONE;
                  end else begin
                     r_d = r_q + R_ONE;
                  end
               end else begin
                  c_d = c_q + C_ONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         c_q      <= '0;
         r_q      <= '0;
         left_q   <= '0;
         centre_q <= '0;
      end else begin
         state_q  <= state_d;
         c_q      <= c_d;
         r_q      <= r_d;
         left_q   <= left_d;
         centre_q <= centre_d;
      end
   end

   // Line buffers carry no reset; row masking above hides stale rows
   always_ff @(posedge clock) begin
      if (step && in_row) begin
         lb1_q[idx] <= lb0_q[idx];
         lb0_q[idx] <= col_new[2];
      end
   end

`ifdef SOBEL_CTRL_STALL_COUNT_EN
   logic [31:0] stall_count_q, stall_count_d;

   always_comb begin
      stall_count_d = stall_count_q;
      if ((state_q == IDLE) && start)
         stall_count_d = '0;
      else if (busy && !step && (stall_count_q != '1))
         stall_count_d = stall_count_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) stall_count_q <= '0;
      else       stall_count_q <= stall_count_d;
   end

   assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl on a 4x3 frame: scenario table plus reset/back-to-back sequences.
module tb_sobel_window_ctrl;
   localparam int W = 4;
   localparam int H = 3;
   localparam int D = 8;
   localparam int NPIX = W * H;

   logic           clock = 1'b0;
   logic           reset, start, busy, done;
   logic [D-1:0]   in_dout;
   logic           in_empty, in_rd_en;
   logic [9*D-1:0] out_din;
   logic           out_full, out_wr_en;
`ifdef SOBEL_CTRL_STALL_COUNT_EN
   logic [31:0]    stall_count;
`endif

   always #5 clock = ~clock;

   sobel_window_ctrl #(.WIDTH(W), .HEIGHT(H), .DWIDTH(D)) dut (
      .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
      .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
      .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en)
`ifdef SOBEL_CTRL_STALL_COUNT_EN
      , .stall_count(stall_count)
`endif
   );

   typedef struct {
      bit tog;
      int full_at;
      int full_len;
      int exp_pops;
      int exp_pushes;
      int exp_steps;
      int exp_run;
   } vec_t;

   localparam logic [71:0] FIRST_WIN = {8'd6, 8'd5, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
   localparam logic [71:0] LAST_WIN  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd12, 8'd11, 8'd0, 8'd8, 8'd7};

   int             n_checks, n_fail;
   logic [71:0]    exp_q[$];
   logic [D-1:0]   pix [NPIX];
   int             pidx, mr, mc, gc;
   int             pops, pushes, steps, stalls, run_cyc, idle_gap;
   logic [71:0]    first_win, last_win;
   vec_t           vecs [3];

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [71:0] win_exp(input int i, input int j);
      logic [71:0] w;
      w = '0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++) begin
            int y, x;
            y = i + dr - 1;
            x = j + dc - 1;
            if (y >= 0 && y < H && x >= 0 && x < W) w[D*(dr*3+dc) +: D] = pix[y*W + x];
         end
      return w;
   endfunction

   // Drives one frame cycle by cycle; the bench tracks its own grid position and FIFO contents.
   task automatic run_frame(input bit tog, input int full_at, input int full_len,
                            input bit keep_start, input int abort_at);
      bit fin, got_busy, first_push, hold_done;
      int full_left, last_push_k;
      logic [71:0] held;
      pidx = 0; mr = 0; mc = 0;
      pops = 0; pushes = 0; steps = 0; stalls = 0; run_cyc = 0; idle_gap = 0;
      fin = 0; got_busy = 0; first_push = 1; hold_done = 0; full_left = 0; last_push_k = -1;
      held = '0;
      for (int i = 0; i < H; i++)
         for (int j = 0; j < W; j++) exp_q.push_back(win_exp(i, j));
      for (int k = 0; k < 400 && !fin; k++) begin
         bit rl, em, stp;
         @(negedge clock);
         start = (k == 0) || keep_start;
         rl = (mr < H) && (mc < W);
         em = (mr >= 1) && (mc >= 1);
         if (full_at >= 0 && busy && em && pushes == full_at && !hold_done) begin
            full_left = full_len;
            hold_done = 1;
         end
         out_full = (full_left > 0);
         in_empty = (pidx >= NPIX) || (tog && (gc % 2 == 1));
         in_dout  = (pidx < NPIX) ? pix[pidx] : '0;
         #1;
         stp = busy && !(rl && in_empty) && !(em && out_full);
         if (busy) begin
            if (!got_busy) begin
               got_busy = 1;
`ifdef SOBEL_CTRL_STALL_COUNT_EN
               chk("stall_count_cleared", stall_count, 0);
`endif
            end
            run_cyc++;
            chk("in_rd_en", in_rd_en, stp && rl);
            chk("out_wr_en", out_wr_en, stp && em);
            if (full_left > 0) begin
               if (full_left == full_len) held = out_din;
               else chk("hold_out_din", out_din, held);
               full_left--;
            end
            if (out_wr_en) begin
               if (first_push) begin
                  chk("first_push_rd_en", in_rd_en, 1);
                  chk("first_push_pop_no", pops + 1, 6);
                  first_win  = out_din;
                  first_push = 0;
               end
               if (exp_q.size() == 0) chk("window_unexpected", out_din, 72'h0 - 72'h1);
               else chk("window", out_din, exp_q.pop_front());
               last_win = out_din;
               pushes++;
               last_push_k = k;
            end
            if (in_rd_en) begin
               pidx++;
               pops++;
            end
            if (stp) begin
               steps++;
               if (mc == W) begin
                  mc = 0;
                  mr = (mr == H) ? 0 : mr + 1;
               end else mc++;
            end else stalls++;
            if (abort_at > 0 && steps == abort_at) fin = 1;
         end else begin
            chk("idle_rd_en", in_rd_en, 0);
            chk("idle_wr_en", out_wr_en, 0);
            if (done) begin
               chk("done_after_run", got_busy, 1);
               chk("done_after_last_push", k, last_push_k + 1);
`ifdef SOBEL_CTRL_STALL_COUNT_EN
               chk("stall_count", stall_count, stalls);
`endif
               fin = 1;
            end else if (!got_busy) idle_gap++;
         end
         gc++;
      end
      if (!fin) begin
         n_checks++;
         n_fail++;
         $display("FAIL frame_timeout: got no completion expected done within 400 cycles");
      end
   endtask

   task automatic check_counts(input string tag, input vec_t v);
      chk({tag, "_pops"}, pops, v.exp_pops);
      chk({tag, "_pushes"}, pushes, v.exp_pushes);
      chk({tag, "_steps"}, steps, v.exp_steps);
      if (v.exp_run >= 0) chk({tag, "_run_cycles"}, run_cyc, v.exp_run);
      chk({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   task automatic after_done();
      @(negedge clock);
      start = 1'b0;
      out_full = 1'b0;
      #1;
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test expected finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0; n_fail = 0; gc = 0;
      reset = 1'b1; start = 1'b0; in_empty = 1'b0; out_full = 1'b0; in_dout = 8'hAA;
      for (int k = 0; k < NPIX; k++) pix[k] = D'(k + 1);
      vecs[0] = '{tog: 1'b0, full_at: -1, full_len: 0,  exp_pops: 12, exp_pushes: 12, exp_steps: 20, exp_run: 20};
      vecs[1] = '{tog: 1'b1, full_at: -1, full_len: 0,  exp_pops: 12, exp_pushes: 12, exp_steps: 20, exp_run: -1};
      vecs[2] = '{tog: 1'b0, full_at: 2,  full_len: 10, exp_pops: 12, exp_pushes: 12, exp_steps: 20, exp_run: 30};

      repeat (3) @(posedge clock);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", in_rd_en, 0);
      chk("rst_wr_en", out_wr_en, 0);
      chk("rst_out_din", out_din, 0);
`ifdef SOBEL_CTRL_STALL_COUNT_EN
      chk("rst_stall_count", stall_count, 0);
`endif
      @(negedge clock);
      reset = 1'b0;

      for (int v = 0; v < 3; v++) begin
         run_frame(vecs[v].tog, vecs[v].full_at, vecs[v].full_len, 1'b0, -1);
         check_counts($sformatf("vec%0d", v), vecs[v]);
         chk("first_window", first_win, FIRST_WIN);
         chk("last_window", last_win, LAST_WIN);
         after_done();
      end

      // Abort mid-frame with reset, then a fresh frame must match the plain run
      run_frame(1'b0, -1, 0, 1'b0, 8);
      @(negedge clock);
      reset = 1'b1;
      start = 1'b0;
      in_empty = 1'b0;
      @(posedge clock);
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_rd_en", in_rd_en, 0);
      chk("abort_wr_en", out_wr_en, 0);
      chk("abort_done", done, 0);
      @(negedge clock);
      reset = 1'b0;
      exp_q.delete();
      run_frame(1'b0, -1, 0, 1'b0, -1);
      check_counts("after_abort", vecs[0]);
      chk("after_abort_first", first_win, FIRST_WIN);
      chk("after_abort_last", last_win, LAST_WIN);
      after_done();

      // start held across two frames: DONE then IDLE, then the next RUN
      run_frame(1'b0, -1, 0, 1'b1, -1);
      check_counts("b2b_f1", vecs[0]);
      run_frame(1'b0, -1, 0, 1'b1, -1);
      check_counts("b2b_f2", vecs[0]);
      chk("b2b_gap", idle_gap, 1);
      chk("b2b_first", first_win, FIRST_WIN);
      after_done();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
